outpkt_arbiter: RTL

- Shares the single 16-bit output FIFO between N_SRC output-packet sources: word packets, status/error packets, and future result packets.
- Grants are packet-atomic and round-robin. Once a source is granted, every word up to and including its pkt_end word is forwarded contiguously.
- Sits between the per-type outpkt/outpkt_checksum chains and the high-speed output FIFO, in the CLK domain.

---
 rtl/outpkt_arbiter_pkg.sv | 19 +
 rtl/outpkt_arbiter_rr_select.sv | 30 +++
 rtl/outpkt_arbiter.sv | 107 ++++++++++
 3 files changed

// File: rtl/outpkt_arbiter_pkg.sv
// rtl/outpkt_arbiter_pkg.sv - shared outpkt constants, arbiter state type and MSB macro
`ifndef MSB
`define MSB(x) ($clog2((x) + 1) - 1)
`endif

package outpkt_arbiter_pkg;

  localparam int OUTPKT_W = 16;

  localparam logic [1:0] PKT_TYPE_WORD   = 2'd0;
  localparam logic [1:0] PKT_TYPE_STATUS = 2'd1;
  localparam logic [1:0] PKT_TYPE_RESULT = 2'd2;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_XFER = 1'b1
  } arb_state_t;

endpackage

// File: rtl/outpkt_arbiter_rr_select.sv
// rtl/outpkt_arbiter_rr_select.sv - round-robin picker: first requester after the last grant
module outpkt_arbiter_rr_select
  import outpkt_arbiter_pkg::*;
#(
  parameter int N_SRC = 2,
  parameter int GW    = `MSB(N_SRC - 1) + 1
) (
  input  logic [N_SRC-1:0] req,
  input  logic [GW-1:0]    last,
  output logic [GW-1:0]    pick,
  output logic             valid
);

  logic [GW-1:0] idx;

  // Walk the ring backwards so the nearest requester after 'last' is written last and wins.
  always_comb begin
    pick  = last;
    valid = 1'b0;
    idx   = '0;
    for (int k = N_SRC; k >= 1; k--) begin
      idx = GW'((int'(last) + k) % N_SRC);
      if (req[idx]) begin
        pick  = idx;
        valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/outpkt_arbiter.sv
// rtl/outpkt_arbiter.sv - packet-atomic round-robin arbiter feeding the 16-bit output FIFO
module outpkt_arbiter
  import outpkt_arbiter_pkg::*;
#(
  parameter int N_SRC         = 2,
  parameter int MAX_PKT_WORDS = 1024,
  parameter int CNT_MSB       = `MSB(MAX_PKT_WORDS)
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic                      enable,
  input  logic [OUTPKT_W*N_SRC-1:0] src_dout,
  input  logic [N_SRC-1:0]          src_pkt_end,
  input  logic [N_SRC-1:0]          src_empty,
  output logic [N_SRC-1:0]          src_rd_en,
  output logic [OUTPKT_W-1:0]       dout,
  output logic                      wr_en,
  input  logic                      full,
  output logic [`MSB(N_SRC-1):0]    grant,
  output logic                      busy,
  output logic [15:0]               pkt_count,
  output logic                      err_pkt_len
);

  localparam int GW = `MSB(N_SRC - 1) + 1;
  localparam logic [CNT_MSB:0] CNT_LIMIT = (CNT_MSB + 1)'(MAX_PKT_WORDS);

  arb_state_t          state;
  logic                out_valid;
  logic                stage_free;
  logic                pop;
  logic                sel_valid;
  logic [GW-1:0]       sel;
  logic [CNT_MSB:0]    word_cnt;
  logic [CNT_MSB:0]    cnt_inc;
  logic [OUTPKT_W-1:0] src_word [N_SRC];

  for (genvar i = 0; i < N_SRC; i++) begin : g_unpack
    assign src_word[i] = src_dout[OUTPKT_W*i +: OUTPKT_W];
  end

  outpkt_arbiter_rr_select #(
    .N_SRC (N_SRC),
    .GW    (GW)
  ) u_rr_select (
    .req   (~src_empty),
    .last  (grant),
    .pick  (sel),
    .valid (sel_valid)
  );

  // The one-word output stage refills in the same cycle it drains, giving 1 word/cycle.
  assign wr_en      = out_valid & ~full;
  assign stage_free = ~out_valid | wr_en;
  assign busy       = (state == ST_XFER);
  assign pop        = busy & ~src_empty[grant] & stage_free;
  assign cnt_inc    = word_cnt + 1'b1;

  always_comb begin
    src_rd_en        = '0;
    src_rd_en[grant] = pop;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state       <= ST_IDLE;
      grant       <= GW'(N_SRC - 1);
      out_valid   <= 1'b0;
      dout        <= '0;
      pkt_count   <= '0;
      err_pkt_len <= 1'b0;
      word_cnt    <= '0;
    end else begin
      if (pop) begin
        dout      <= src_word[grant];
        out_valid <= 1'b1;
      end else if (wr_en) begin
        out_valid <= 1'b0;
      end

      case (state)
        ST_IDLE: begin
          if (enable && sel_valid) begin
            grant    <= sel;
            word_cnt <= '0;
            state    <= ST_XFER;
          end
        end
        ST_XFER: begin
          // An empty source simply stalls here; only pkt_end or the watchdog releases the grant.
          if (pop) begin
            word_cnt <= cnt_inc;
            if (src_pkt_end[grant]) begin
              pkt_count <= pkt_count + 16'd1;
              state     <= ST_IDLE;
            end else if (cnt_inc == CNT_LIMIT) begin
              err_pkt_len <= 1'b1;
              state       <= ST_IDLE;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
